// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory read bus with a single outstanding request
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with a 2-entry prefetch queue, redirect and stall handling
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            PC,
  output logic [31:0]            instruction,
  output logic                   flush,
  output logic                   valid
);
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d, ins0_q, ins0_d, ins1_q, ins1_d;
  logic        req_q, req_d, drop_q, drop_d;
  logic [1:0]  count_q, count_d, level;
  logic        wait_ack, pop, push;
  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    wait_ack = req_q && !imem.imem_ack;
    pop      = !freeze && count_q != 2'd0;
    push     = req_q && imem.imem_ack && !drop_q && !branch_taken;
    level    = count_q - {1'b0, pop};
    count_d  = branch_taken ? 2'd0 : level + {1'b0, push};
    pc_d     = branch_taken ? branch_target : push ? pc_q + 32'd4 : pc_q;
    drop_d   = wait_ack && (drop_q || branch_taken);
    req_d    = wait_ack || count_d < 2'd2;
    addr_d   = wait_ack ? addr_q : pc_d;
    pc0_d    = pop ? pc1_q : pc0_q;
    ins0_d   = pop ? ins1_q : ins0_q;
    pc1_d    = pc1_q;
    ins1_d   = ins1_q;
    if (push && level == 2'd0) begin
      pc0_d  = addr_q + 32'd4;
      ins0_d = imem.imem_rdata;
    end
    if (push && level == 2'd1) begin
      pc1_d  = addr_q + 32'd4;
      ins1_d = imem.imem_rdata;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      addr_q  <= 32'd0;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      count_q <= 2'd0;
      pc0_q   <= 32'd0;
      pc1_q   <= 32'd0;
      ins0_q  <= 32'd0;
      ins1_q  <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      ins0_q  <= ins0_d;
      ins1_q  <= ins1_d;
    end
  end
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign valid          = count_q != 2'd0;
  assign PC             = valid ? pc0_q : 32'd0;
  assign instruction    = valid ? ins0_q : 32'd0;
  assign flush          = branch_taken;
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have input clk (1), the single clock; all state changes occur on posedge clk.
REQ-003 The block SHALL have input rst (1), the reset, asynchronous and active-low.
REQ-004 The block SHALL have input freeze (1), pipeline stall from the hazard unit; the IF/ID register does not capture while freeze=1.
REQ-005 The block SHALL have input branch_taken (1), a one-cycle redirect request from ID.
REQ-006 The block SHALL have input branch_target (32), the redirect address, sampled when branch_taken=1.
REQ-007 The block SHALL have output imem_req (1), the instruction-memory read request, registered.
REQ-008 The block SHALL have output imem_addr (32), the read address, registered.
REQ-009 The block SHALL have input imem_ack (1), the read completion, valid only while imem_req=1.
REQ-010 The block SHALL have input imem_rdata (32), the read data, valid in the cycle imem_ack=1.
REQ-011 The block SHALL have output PC (32), which carries fetch address + 4 of the head entry, and 0 when the queue is empty.
REQ-012 The block SHALL have output instruction (32), which carries the head instruction, and 0 (bubble) when the queue is empty.
REQ-013 The block SHALL have output flush (1), wired combinationally to branch_taken and driving the IF/ID flush input.
REQ-014 The block SHALL have output valid (1), which is 1 when the queue count > 0.

Function
REQ-015 Memory protocol: imem_addr SHALL stay stable while imem_req=1 until an edge with imem_ack=1; at that edge the transfer completes.
REQ-016 The block SHALL allow at most one outstanding request.
REQ-017 The block SHALL hold a 2-entry FIFO of {fetch_addr+4, instruction} with count 0..2.
REQ-018 Consume: at a posedge with freeze=0 and count>0, the head SHALL be popped.
REQ-019 Capture: at a posedge with imem_ack=1 and drop=0, {imem_addr+4, imem_rdata} SHALL be pushed; push and pop in the same edge leave count unchanged.
REQ-020 After each capture, pc_reg SHALL advance by 4 (wrap modulo 2^32; 32'hFFFFFFFC -> 0).
REQ-021 Request issue: imem_req_next SHALL be (imem_req && !imem_ack) || (count_next + 0 < 2), and imem_addr_next SHALL equal pc_next whenever a new request starts.
REQ-022 With freeze=0 and ack every cycle, the block SHALL deliver one instruction per cycle (count steady at 1).
REQ-023 With freeze=1 and count=2, the block SHALL keep imem_req=0 and SHALL NOT lose, duplicate or reorder any instruction.
REQ-024 Redirect: at a posedge with branch_taken=1, the block SHALL set pc_reg to branch_target and count to 0, and SHALL discard any push in the same edge.
REQ-025 Redirect while a request is outstanding without ack: the block SHALL set drop=1 and keep imem_req/imem_addr unchanged until ack; the acked data SHALL be discarded and drop cleared; the next request goes to pc_reg.
REQ-026 Redirect in the same cycle as ack: the block SHALL discard the data, and the next request SHALL address branch_target.
REQ-027 Repeated redirects while drop=1: the block SHALL use the last target.
REQ-028 If branch_taken and freeze are both 1, the redirect SHALL still take effect; flush=1 is ignored by IF/ID in that cycle per its freeze priority.

Reset
REQ-029 While rst=0, all outputs SHALL immediately be imem_req=0, imem_addr=0, PC=0, instruction=0, valid=0, count=0, drop=0, pc_reg=RESET_PC.
REQ-030 On the first posedge after rst rises, the block SHALL set imem_req=1 and imem_addr=RESET_PC.
REQ-031 Reset mid-transaction SHALL abandon the request with no data captured.

Verification
REQ-032 Reset, ack every cycle, freeze=0, RESET_PC=0 -> outputs (PC,instruction) = (4,mem[0]), (8,mem[4]), (12,mem[8]) on consecutive cycles; valid stays 1.
REQ-033 freeze=1 for 4 cycles in steady stream -> count reaches 2, imem_req drops, outputs stable; after release the next two outputs are the held entries in order.
REQ-034 Outstanding req to 0x8 with ack delayed 3 cycles, branch_taken target 0x100 -> flush=1 that cycle, addr 0x8 is held until ack, its data is never output, next imem_addr=0x100, first output PC=0x104.
REQ-035 branch_taken coincident with ack of 0xC (target 0x40) -> the 0xC data is dropped, next request is 0x40, valid=0 the following cycle.
REQ-036 rst=0 asynchronously mid-wait -> imem_req=0 and valid=0 before the next edge; after release the fetch restarts at RESET_PC.
REQ-037 pc_reg=32'hFFFFFFFC with ack -> PC output=0 and the next imem_addr=0.
